// File: rtl/axi_stream_remove_header.sv
// axi_stream_remove_header: strips a per-packet byte count from the head of an
// AXI-Stream packet, reports the stripped bytes and re-aligns the payload MSB-first.
module axi_stream_remove_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_remove,
    input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
    output logic                    ready_remove,
    output logic                    hdr_valid,
    output logic [DATA_WD-1:0]      hdr_data,
    output logic [DATA_BYTE_WD-1:0] hdr_keep,
    output logic                    hdr_err
);
    localparam logic [BYTE_CNT_WD-1:0]  WB  = BYTE_CNT_WD'(DATA_BYTE_WD);
    localparam logic [DATA_BYTE_WD-1:0] ALL = '1;

    typedef enum logic [1:0] {IDLE, HEAD, STREAM, FLUSH} state_t;

    state_t                  state_q, state_d;
    logic [BYTE_CNT_WD-1:0]  cnt_q, cnt_d, rem_cnt;
    logic [DATA_WD-1:0]      res_q, res_d;
    logic [DATA_BYTE_WD-1:0] res_keep_q, res_keep_d;
    logic                    valid_q, valid_d, last_q, last_d;
    logic [DATA_WD-1:0]      data_q, data_d;
    logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
    logic                    hdr_valid_q, hdr_valid_d, hdr_err_q, hdr_err_d;
    logic [DATA_WD-1:0]      hdr_data_q, hdr_data_d;
    logic [DATA_BYTE_WD-1:0] hdr_keep_q, hdr_keep_d;
    logic                    adv, hs, beat_v, beat_l;
    logic [DATA_WD-1:0]      beat_d, sh_data;
    logic [DATA_BYTE_WD-1:0] beat_k, sh_keep, head_keep;

    function automatic logic [DATA_WD-1:0] bmask(input logic [DATA_BYTE_WD-1:0] k);
        for (int i = 0; i < DATA_BYTE_WD; i++) bmask[8*i +: 8] = {8{k[i]}};
    endfunction

    assign adv          = !valid_q || ready_out;
    assign ready_in     = (state_q == HEAD || state_q == STREAM) && adv;
    assign ready_remove = state_q == IDLE;
    assign hs           = valid_in && ready_in;
    assign rem_cnt      = WB - cnt_q;
    // residual kept left-aligned; its keep doubles as the FLUSH beat keep
    assign sh_data      = data_in << {cnt_q, 3'b000};
    assign sh_keep      = keep_in << cnt_q;
    assign head_keep    = ~(ALL >> cnt_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        res_keep_d  = res_keep_q;
        hdr_valid_d = 1'b0;
        hdr_err_d   = 1'b0;
        hdr_data_d  = hdr_data_q;
        hdr_keep_d  = hdr_keep_q;
        beat_v      = 1'b0;
        beat_d      = '0;
        beat_k      = '0;
        beat_l      = 1'b0;
        case (state_q)
            IDLE: if (valid_remove) begin
                cnt_d   = byte_remove_cnt > WB ? WB : byte_remove_cnt;
                state_d = HEAD;
            end
            HEAD: if (hs) begin
                res_d       = sh_data;
                res_keep_d  = sh_keep;
                hdr_err_d   = |(head_keep & ~keep_in);
                hdr_valid_d = !hdr_err_d;
                hdr_data_d  = data_in & bmask(head_keep);
                hdr_keep_d  = head_keep;
                beat_v      = (|sh_keep) && (cnt_q == '0 || last_in);
                beat_d      = sh_data;
                beat_k      = sh_keep;
                beat_l      = last_in;
                state_d     = last_in ? IDLE : STREAM;
            end
            STREAM: if (hs) begin
                res_d      = sh_data;
                res_keep_d = sh_keep;
                beat_v     = 1'b1;
                beat_d     = cnt_q == '0 ? data_in : res_q | (data_in >> {rem_cnt, 3'b000});
                beat_k     = cnt_q == '0 ? keep_in : (ALL << cnt_q) | (keep_in >> rem_cnt);
                beat_l     = last_in && (cnt_q == '0 || ~|sh_keep);
                state_d    = last_in ? (beat_l ? IDLE : FLUSH) : STREAM;
            end
            FLUSH: if (adv) begin
                beat_v  = 1'b1;
                beat_d  = res_q;
                beat_k  = res_keep_q;
                beat_l  = 1'b1;
                state_d = IDLE;
            end
        endcase
        valid_d = adv ? beat_v : valid_q;
        data_d  = adv ? beat_d & bmask(beat_k) : data_q;
        keep_d  = adv ? beat_k : keep_q;
        last_d  = adv ? beat_l : last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            res_q       <= '0;
            res_keep_q  <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            keep_q      <= '0;
            last_q      <= 1'b0;
            hdr_valid_q <= 1'b0;
            hdr_err_q   <= 1'b0;
            hdr_data_q  <= '0;
            hdr_keep_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            res_keep_q  <= res_keep_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            keep_q      <= keep_d;
            last_q      <= last_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_err_q   <= hdr_err_d;
            hdr_data_q  <= hdr_data_d;
            hdr_keep_q  <= hdr_keep_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign keep_out  = keep_q;
    assign last_out  = last_q;
    assign hdr_valid = hdr_valid_q;
    assign hdr_err   = hdr_err_q;
    assign hdr_data  = hdr_data_q;
    assign hdr_keep  = hdr_keep_q;
endmodule

// File: tb/tb_axi_stream_remove_header.sv
// tb_axi_stream_remove_header: directed and random packets checked against a
// byte-queue model of header stripping and payload regrouping.
module tb_axi_stream_remove_header;
    localparam int DW = 32;
    localparam int W  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          valid_in = 1'b0, last_in = 1'b0, ready_in;
    logic [DW-1:0] data_in = '0, data_out, hdr_data;
    logic [W-1:0]  keep_in = '0, keep_out, hdr_keep;
    logic          valid_out, last_out, ready_out = 1'b1;
    logic          valid_remove = 1'b0, ready_remove, hdr_valid, hdr_err;
    logic [CW-1:0] byte_remove_cnt = '0;

    always #5 clk = ~clk;

    axi_stream_remove_header dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
        .valid_remove(valid_remove), .byte_remove_cnt(byte_remove_cnt), .ready_remove(ready_remove),
        .hdr_valid(hdr_valid), .hdr_data(hdr_data), .hdr_keep(hdr_keep), .hdr_err(hdr_err)
    );

    typedef struct packed {logic [DW-1:0] d; logic [W-1:0] k; logic l;} beat_t;
    typedef struct packed {logic e; logic [DW-1:0] d; logic [W-1:0] k;} hdr_t;

    beat_t      exp_q[$];
    hdr_t       hexp_q[$];
    logic [7:0] pb[$];
    int         vecs = 0, errs = 0;
    bit         rnd_ready = 0, mon_en = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: first s bytes form the header; the rest regroup into W-byte beats.
    task automatic model(input int cnt);
        int    s = cnt > W ? W : cnt;
        int    n = pb.size();
        hdr_t  h = '0;
        beat_t b;
        if (n < s) begin
            h.e = 1'b1;
            hexp_q.push_back(h);
            return;
        end
        for (int i = 0; i < s; i++) begin
            h.d[DW-1-8*i -: 8] = pb[i];
            h.k[W-1-i] = 1'b1;
        end
        hexp_q.push_back(h);
        for (int i = s; i < n; i += W) begin
            b = '0;
            for (int j = 0; j < W && i + j < n; j++) begin
                b.d[DW-1-8*j -: 8] = pb[i+j];
                b.k[W-1-j] = 1'b1;
            end
            b.l = (i + W >= n);
            exp_q.push_back(b);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ready_out = rnd_ready ? ($urandom_range(0, 9) >= 2) : 1'b1;
    endtask

    task automatic put_cmd(input int c);
        int   n = 0;
        logic a;
        valid_remove = 1'b1;
        byte_remove_cnt = CW'(c);
        do begin
            @(negedge clk);
            a = ready_remove;
            tick();
            n++;
        end while (!a && n < 300);
        check("cmd_accept", DW'(a), DW'(1));
        valid_remove = 1'b0;
    endtask

    task automatic put_beat(input logic [DW-1:0] d, input logic [W-1:0] k, input logic l);
        int   n = 0;
        logic a;
        valid_in = 1'b1;
        data_in = d;
        keep_in = k;
        last_in = l;
        do begin
            @(negedge clk);
            a = ready_in;
            tick();
            n++;
        end while (!a && n < 300);
        check("beat_accept", DW'(a), DW'(1));
        valid_in = 1'b0;
    endtask

    // Bytes past the packet end carry random filler that must not leak out.
    task automatic send_pkt(input int cnt);
        logic [DW-1:0] d;
        logic [W-1:0]  k;
        model(cnt);
        put_cmd(cnt);
        for (int i = 0; i < pb.size(); i += W) begin
            d = DW'($urandom);
            k = '0;
            for (int j = 0; j < W && i + j < pb.size(); j++) begin
                d[DW-1-8*j -: 8] = pb[i+j];
                k[W-1-j] = 1'b1;
            end
            put_beat(d, k, i + W >= pb.size());
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() + hexp_q.size()) != 0 && n < 500) begin
            tick();
            n++;
        end
        check("drain_left", DW'(exp_q.size() + hexp_q.size()), DW'(0));
    endtask

    initial begin : monitor
        beat_t pv;
        hdr_t  h;
        bit    pst = 0;
        forever begin
            @(negedge clk);
            if (rst_n && mon_en) begin
                if (pst) begin
                    check("stall_valid", DW'(valid_out), DW'(1));
                    check("stall_data", data_out, pv.d);
                    check("stall_keep", DW'(keep_out), DW'(pv.k));
                    check("stall_last", DW'(last_out), DW'(pv.l));
                end
                if (valid_out && ready_out) begin
                    check("out_expected", DW'(exp_q.size() != 0), DW'(1));
                    if (exp_q.size() != 0) begin
                        pv = exp_q.pop_front();
                        check("out_data", data_out, pv.d);
                        check("out_keep", DW'(keep_out), DW'(pv.k));
                        check("out_last", DW'(last_out), DW'(pv.l));
                    end
                end
                pst = valid_out && !ready_out;
                pv.d = data_out;
                pv.k = keep_out;
                pv.l = last_out;
                if (hdr_valid || hdr_err) begin
                    check("hdr_expected", DW'(hexp_q.size() != 0), DW'(1));
                    if (hexp_q.size() != 0) begin
                        h = hexp_q.pop_front();
                        check("hdr_err", DW'(hdr_err), DW'(h.e));
                        check("hdr_valid", DW'(hdr_valid), DW'(!h.e));
                        if (!h.e) begin
                            check("hdr_data", hdr_data, h.d);
                            check("hdr_keep", DW'(hdr_keep), DW'(h.k));
                        end
                    end
                end
            end else pst = 0;
        end
    end

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid_out", DW'(valid_out), DW'(0));
        check("rst_ready_remove", DW'(ready_remove), DW'(1));
        check("rst_ready_in", DW'(ready_in), DW'(0));
        check("rst_hdr_valid", DW'(hdr_valid), DW'(0));
        check("rst_hdr_err", DW'(hdr_err), DW'(0));
        check("rst_data_out", data_out, DW'(0));
        check("rst_keep_out", DW'(keep_out), DW'(0));
        check("rst_hdr_keep", DW'(hdr_keep), DW'(0));
        mon_en = 1;
        tick();
        pb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        send_pkt(0);
        pb = '{8'h48, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h11};
        send_pkt(1);
        pb = '{8'h01, 8'h02, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send_pkt(3);
        pb = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_pkt(4);
        pb = '{8'h01, 8'h02};
        send_pkt(3);
        pb = '{8'h05, 8'h06};
        send_pkt(2);
        pb = '{8'h07, 8'h08, 8'h09};
        send_pkt(1);
        pb = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90};
        send_pkt(7);
        drain();
        rnd_ready = 1;
        for (int p = 0; p < 12; p++) begin
            pb = {};
            repeat ($urandom_range(1, 14)) pb.push_back(8'($urandom));
            send_pkt(int'($urandom_range(0, 4)));
        end
        drain();
        rnd_ready = 0;
        mon_en = 0;
        put_cmd(2);
        put_beat(32'h0102AABB, 4'b1111, 1'b0);
        put_beat(32'hCCDDEEFF, 4'b1111, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("arst_valid_out", DW'(valid_out), DW'(0));
        check("arst_ready_remove", DW'(ready_remove), DW'(1));
        check("arst_ready_in", DW'(ready_in), DW'(0));
        tick();
        rst_n = 1'b1;
        exp_q = {};
        hexp_q = {};
        mon_en = 1;
        pb = '{8'hDE, 8'hAD, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        send_pkt(2);
        drain();
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
